// File: rtl/scan_capture.sv
// Receive side of the multiplexed 7-segment scan bus: synchronizes led/content,
// waits for a stable dwell, and rebuilds the six displayed digits as BCD.
module scan_capture #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  led,
  input  logic [6:0]  content,
  output logic [23:0] digits,
  output logic        frame_done,
  output logic        sel_err,
  output logic        seg_err,
  output logic        scan_lost
);

  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYC);
  localparam logic [23:0] TIMEOUT_MAX = 24'(TIMEOUT_CYC);
  localparam logic [3:0]  BCD_BLANK   = 4'hF;
  localparam logic [3:0]  BCD_BAD     = 4'hE;

  // Active-low {g,f,e,d,c,b,a} pattern to BCD; blank and undecodable get codes.
  function automatic logic [3:0] seg_decode(input logic [6:0] pat);
    unique case (pat)
      7'b1000000: seg_decode = 4'd0;
      7'b1111001: seg_decode = 4'd1;
      7'b0100100: seg_decode = 4'd2;
      7'b0110000: seg_decode = 4'd3;
      7'b0011001: seg_decode = 4'd4;
      7'b0010010: seg_decode = 4'd5;
      7'b0000010: seg_decode = 4'd6;
      7'b1111000: seg_decode = 4'd7;
      7'b0000000: seg_decode = 4'd8;
      7'b0010000: seg_decode = 4'd9;
      7'b1111111: seg_decode = BCD_BLANK;
      default:    seg_decode = BCD_BAD;
    endcase
  endfunction

  logic [7:0]  led_s1_q, led_smp_q, led_prev_q;
  logic [6:0]  con_s1_q, con_smp_q, con_prev_q;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic        captured_q, captured_d;
  logic [5:0]  seen_q, seen_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic [23:0] digits_q, digits_d;
  logic        frame_done_q, frame_done_d;
  logic        sel_err_q, sel_err_d;
  logic        seg_err_q, seg_err_d;
  logic        scan_lost_q, scan_lost_d;

  logic        smp_changed, capture, sel_legal, sel_idle, legal_cap;
  logic [2:0]  sel_idx;
  logic [3:0]  bcd;
  logic [5:0]  seen_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    sel_idx      = 3'd0;
    seen_next    = seen_q;
    digits_d     = digits_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    sel_err_d    = 1'b0;
    seg_err_d    = 1'b0;

    smp_changed = {led_smp_q, con_smp_q} != {led_prev_q, con_prev_q};
    if (smp_changed)                   stab_cnt_d = 8'd0;
    else if (stab_cnt_q == STABLE_MAX) stab_cnt_d = stab_cnt_q;
    else                               stab_cnt_d = stab_cnt_q + 8'd1;

    capture    = !smp_changed && !captured_q && (stab_cnt_d == STABLE_MAX);
    captured_d = capture ? 1'b1 : (smp_changed ? 1'b0 : captured_q);

    sel_legal = (led_smp_q[7:6] == 2'b11) && $onehot(~led_smp_q[5:0]);
    sel_idle  = (led_smp_q == 8'hFF);
    legal_cap = capture && sel_legal;
    for (int i = 0; i < 6; i++) begin
      if (!led_smp_q[i]) sel_idx = 3'(i);
    end
    bcd = seg_decode(con_smp_q);

    if (legal_cap) begin
      digits_d[{sel_idx, 2'b00} +: 4] = bcd;
      seen_next = seen_q | (6'b1 << sel_idx);
      seg_err_d = (bcd == BCD_BAD);
      // The completing capture closes the frame and the mask restarts empty.
      if (seen_next == 6'h3F) begin
        frame_done_d = 1'b1;
        seen_d       = 6'h00;
      end else begin
        seen_d = seen_next;
      end
    end else if (capture && !sel_idle) begin
      sel_err_d = 1'b1;
    end

    if (legal_cap)                    to_cnt_d = 24'd0;
    else if (to_cnt_q == TIMEOUT_MAX) to_cnt_d = to_cnt_q;
    else                              to_cnt_d = to_cnt_q + 24'd1;
    scan_lost_d = !legal_cap && (to_cnt_d == TIMEOUT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
      led_s1_q     <= 8'hFF;
      led_smp_q    <= 8'hFF;
      led_prev_q   <= 8'hFF;
      con_s1_q     <= 7'h7F;
      con_smp_q    <= 7'h7F;
      con_prev_q   <= 7'h7F;
      stab_cnt_q   <= 8'd0;
      captured_q   <= 1'b0;
      seen_q       <= 6'h00;
      to_cnt_q     <= 24'd0;
      digits_q     <= 24'hFFFFFF;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
      seg_err_q    <= 1'b0;
      scan_lost_q  <= 1'b0;
    end else begin
      led_s1_q     <= led;
      led_smp_q    <= led_s1_q;
      led_prev_q   <= led_smp_q;
      con_s1_q     <= content;
      con_smp_q    <= con_s1_q;
      con_prev_q   <= con_smp_q;
      stab_cnt_q   <= stab_cnt_d;
      captured_q   <= captured_d;
      seen_q       <= seen_d;
      to_cnt_q     <= to_cnt_d;
      digits_q     <= digits_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
      seg_err_q    <= seg_err_d;
      scan_lost_q  <= scan_lost_d;
    end
  end

  assign digits     = digits_q;
  assign frame_done = frame_done_q;
  assign sel_err    = sel_err_q;
  assign seg_err    = seg_err_q;
  assign scan_lost  = scan_lost_q;

endmodule
